// File: rtl/fpu_pkg.sv
// Shared FPU types: op codes, exception width and the recoded result payload.
package fpu_pkg;

  typedef enum logic [1:0] {
    OP_ADDSUB  = 2'b00,
    OP_MUL     = 2'b01,
    OP_DIVSQRT = 2'b10,
    OP_NONE    = 2'b11
  } fpu_op_e;

  localparam int unsigned EXC_W     = 5;
  localparam int unsigned DATA_W    = 16;
  localparam int unsigned NUM_UNITS = 3;

  typedef struct packed {
    logic [DATA_W:0]  data;
    logic [EXC_W-1:0] exc;
  } fpu_result_t;

endpackage

// File: rtl/fpu_tag_fifo.sv
// Order FIFO for dispatched op codes; pointers carry one extra wrap bit.
module fpu_tag_fifo #(
  parameter int unsigned WIDTH = 2,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int unsigned AW      = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr;
  logic [AW:0]      rptr;

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign head  = mem[rptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push && !full)  wptr <= wptr + PTR_ONE;
      if (pop && !empty)  rptr <= rptr + PTR_ONE;
    end
  end

  // Storage needs no reset: entries are only read while non-empty.
  always_ff @(posedge clk) begin
    if (push && !full) mem[wptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/fpu_result_collector.sv
// FPU return path: buffers per-unit results and releases them in dispatch order.
// Result payloads use fpu_result_t, so DATA_WIDTH is expected to equal fpu_pkg::DATA_W.
module fpu_result_collector
  import fpu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_W,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  issue_valid,
  input  logic [1:0]            issue_op,
  output logic                  issue_ready,
  input  logic                  add_valid,
  input  logic [DATA_WIDTH:0]   add_data,
  input  logic [EXC_W-1:0]      add_exc,
  output logic                  add_ready,
  input  logic                  mul_valid,
  input  logic [DATA_WIDTH:0]   mul_data,
  input  logic [EXC_W-1:0]      mul_exc,
  output logic                  mul_ready,
  input  logic                  div_valid,
  input  logic [DATA_WIDTH:0]   div_data,
  input  logic [EXC_W-1:0]      div_exc,
  output logic                  div_ready,
  output logic                  out_valid,
  output logic [DATA_WIDTH:0]   out_data,
  output logic [EXC_W-1:0]      out_exc,
  output logic [1:0]            out_op,
  input  logic                  out_ready,
  output logic                  err_illegal,
  output logic                  err_spurious
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic                 push;
  logic                 pop;
  logic                 full;
  logic                 empty;
  logic [1:0]           head_op;
  fpu_result_t          hold        [NUM_UNITS];
  logic [NUM_UNITS-1:0] hold_full;
  logic [CW-1:0]        outstanding [NUM_UNITS];
  fpu_result_t          in_res      [NUM_UNITS];
  logic [NUM_UNITS-1:0] in_valid;
  logic [NUM_UNITS-1:0] in_ready;
  logic [NUM_UNITS-1:0] unit_pop;
  logic [NUM_UNITS-1:0] issue_inc;
  logic [NUM_UNITS-1:0] cap;
  logic [NUM_UNITS-1:0] spur;

  assign push        = issue_valid && !full && (issue_op != 2'(OP_NONE));
  assign pop         = out_valid && out_ready;
  assign issue_ready = !full;
  assign add_ready   = in_ready[0];
  assign mul_ready   = in_ready[1];
  assign div_ready   = in_ready[2];

  fpu_tag_fifo #(.WIDTH(2), .DEPTH(DEPTH)) u_order (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (issue_op),
    .pop       (pop),
    .full      (full),
    .empty     (empty),
    .head      (head_op)
  );

  always_comb begin
    in_valid  = {div_valid, mul_valid, add_valid};
    in_res[0] = '{data: add_data, exc: add_exc};
    in_res[1] = '{data: mul_data, exc: mul_exc};
    in_res[2] = '{data: div_data, exc: div_exc};
  end

  // Output mux: only the hold register of the oldest logged op may present.
  always_comb begin
    out_valid = 1'b0;
    out_data  = '0;
    out_exc   = '0;
    out_op    = '0;
    for (int u = 0; u < NUM_UNITS; u++) begin
      if (!empty && head_op == 2'(u) && hold_full[u]) begin
        out_valid = 1'b1;
        out_data  = hold[u].data;
        out_exc   = hold[u].exc;
        out_op    = head_op;
      end
    end
  end

  // Capture eligibility counts an op issued in this same cycle as outstanding.
  always_comb begin
    unit_pop  = '0;
    in_ready  = '0;
    issue_inc = '0;
    cap       = '0;
    spur      = '0;
    for (int u = 0; u < NUM_UNITS; u++) begin
      unit_pop[u]  = pop && (head_op == 2'(u));
      in_ready[u]  = !hold_full[u] || unit_pop[u];
      issue_inc[u] = push && (issue_op == 2'(u));
      cap[u]       = in_valid[u] && in_ready[u] && ((outstanding[u] != '0) || issue_inc[u]);
      spur[u]      = in_valid[u] && in_ready[u] && (outstanding[u] == '0) && !issue_inc[u];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_full    <= '0;
      err_illegal  <= 1'b0;
      err_spurious <= 1'b0;
      for (int u = 0; u < NUM_UNITS; u++) begin
        hold[u]        <= '0;
        outstanding[u] <= '0;
      end
    end else begin
      for (int u = 0; u < NUM_UNITS; u++) begin
        if (cap[u]) begin
          hold[u]      <= in_res[u];
          hold_full[u] <= 1'b1;
        end else if (unit_pop[u]) begin
          hold_full[u] <= 1'b0;
        end
        outstanding[u] <= outstanding[u] + CW'(issue_inc[u]) - CW'(cap[u]);
      end
      if (issue_valid && issue_op == 2'(OP_NONE)) err_illegal <= 1'b1;
      if (|spur) err_spurious <= 1'b1;
    end
  end

endmodule
